// File: rtl/wb_cam_pkg.sv
// Shared definitions for the Wishbone camera capture block: register map,
// control/status bit positions, FSM encoding and sizing helpers.
package wb_cam_pkg;

    localparam logic [2:0] REG_CTRL      = 3'd0;
    localparam logic [2:0] REG_STATUS    = 3'd1;
    localparam logic [2:0] REG_DATA      = 3'd2;
    localparam logic [2:0] REG_FRAME_CNT = 3'd3;
    localparam logic [2:0] REG_GEOM      = 3'd4;

    localparam int CTRL_EN     = 0;
    localparam int CTRL_CONT   = 1;
    localparam int CTRL_FLUSH  = 2;
    localparam int CTRL_IRQ_EN = 3;

    localparam int ST_EMPTY = 0;
    localparam int ST_FULL  = 1;
    localparam int ST_OVF   = 2;
    localparam int ST_DONE  = 3;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_WAIT_VS = 2'd1,
        S_CAPTURE = 2'd2,
        S_DONE    = 2'd3
    } cam_state_t;

    function automatic int calc_pack(input int dat_w, input int pix_w);
        return dat_w / pix_w;
    endfunction

    function automatic int calc_log2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

endpackage

// File: rtl/cam_sync_fifo.sv
// Single-clock first-word-fall-through FIFO; o_dout shows the head word
// whenever the FIFO is not empty. Flush dominates a simultaneous push.
module cam_sync_fifo
    import wb_cam_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = 16,
    localparam int AW   = calc_log2(DEPTH),
    localparam int LW   = AW + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_push,
    input  logic [WIDTH-1:0] i_din,
    input  logic             i_pop,
    input  logic             i_flush,
    output logic [WIDTH-1:0] o_dout,
    output logic [LW-1:0]    o_level,
    output logic             o_empty,
    output logic             o_full
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [LW-1:0]    r_count;
    logic             w_do_pop;
    logic             w_do_push;

    assign o_empty   = (r_count == '0);
    assign o_full    = (r_count == LW'(DEPTH));
    assign o_level   = r_count;
    assign o_dout    = r_mem[r_rd_ptr];
    // A pop frees a slot in the same cycle, so a full FIFO still accepts a push then.
    assign w_do_pop  = i_pop & ~o_empty;
    assign w_do_push = i_push & (~o_full | w_do_pop);

    always_ff @(posedge clk) begin
        if (rst || i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_do_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            r_count <= r_count + LW'(w_do_push) - LW'(w_do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && !i_flush && w_do_push) r_mem[r_wr_ptr] <= i_din;
    end

endmodule

// File: rtl/wb_cam_capture.sv
// Wishbone slave that oversamples an OV-style parallel sensor, packs pixels
// into bus words, buffers them in a FIFO and reports frame statistics.
module wb_cam_capture
    import wb_cam_pkg::*;
#(
    parameter int WB_DAT_WIDTH = 32,
    parameter int WB_ADR_WIDTH = 32,
    parameter int PIX_WIDTH    = 8,
    parameter int FIFO_DEPTH   = 16,
    parameter int XCLK_DIV     = 2
) (
    input  logic                      clk,
    input  logic                      rst,
    output logic                      xclk,
    input  logic                      pclk,
    input  logic                      href,
    input  logic                      vsync,
    input  logic [PIX_WIDTH-1:0]      pix_d,
    input  logic [WB_ADR_WIDTH-1:0]   wb_adr_i,
    input  logic [WB_DAT_WIDTH-1:0]   wb_dat_i,
    input  logic                      wb_we_i,
    input  logic                      wb_cyc_i,
    input  logic                      wb_stb_i,
    input  logic [WB_DAT_WIDTH/8-1:0] wb_sel_i,
    output logic [WB_DAT_WIDTH-1:0]   wb_dat_o,
    output logic                      wb_ack_o,
    output logic                      irq
);

    localparam int PACK    = calc_pack(WB_DAT_WIDTH, PIX_WIDTH);
    localparam int LW      = calc_log2(FIFO_DEPTH) + 1;
    localparam int PACK_CW = calc_log2(PACK) + 1;

    // Sensor synchronizers: [0]=s1, [1]=s2, [2]=history
    logic [2:0]           r_pclk_sh, r_href_sh, r_vs_sh;
    logic [PIX_WIDTH-1:0] r_pix_s1, r_pix_s2;
    logic [15:0]          r_xclk_cnt;
    logic                 r_xclk;

    cam_state_t           r_state, w_state_next;
    logic                 r_ctrl_en, r_ctrl_cont, r_ctrl_irq_en;
    logic                 r_ovf, r_frame_done, r_irq;
    logic [PACK_CW-1:0]   r_pack_cnt;
    logic [WB_DAT_WIDTH-1:0] r_pack_word, w_pack_word, w_push_data;
    logic [15:0]          r_line_pix, r_last_line, r_line_cnt;
    logic [15:0]          r_geom_pix, r_geom_lines, r_frame_cnt;
    logic                 r_ack, r_pop_pend;
    logic [WB_DAT_WIDTH-1:0] r_dat_o, w_rd_data;

    logic w_pclk_rise, w_vs_fall, w_vs_rise, w_href_fall;
    logic w_req, w_wr, w_ctrl_wr, w_stat_wr, w_abort, w_flush;
    logic w_start, w_pixel, w_pack_full, w_partial, w_frame_end, w_push, w_ovf_evt;
    logic [2:0] w_addr;
    logic [WB_DAT_WIDTH-1:0] w_dout;
    logic [LW-1:0] w_level;
    logic w_empty, w_full;
    logic w_unused;

    assign w_unused = ^{wb_adr_i[WB_ADR_WIDTH-1:5], wb_adr_i[1:0], wb_sel_i,
                        wb_dat_i[WB_DAT_WIDTH-1:4]};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_xclk_cnt <= '0;
            r_xclk     <= 1'b0;
            r_pclk_sh  <= '0;
            r_href_sh  <= '0;
            r_vs_sh    <= '0;
            r_pix_s1   <= '0;
            r_pix_s2   <= '0;
        end else begin
            if (r_xclk_cnt == 16'(XCLK_DIV - 1)) begin
                r_xclk_cnt <= '0;
                r_xclk     <= ~r_xclk;
            end else begin
                r_xclk_cnt <= r_xclk_cnt + 16'd1;
            end
            r_pclk_sh <= {r_pclk_sh[1:0], pclk};
            r_href_sh <= {r_href_sh[1:0], href};
            r_vs_sh   <= {r_vs_sh[1:0], vsync};
            r_pix_s1  <= pix_d;
            r_pix_s2  <= r_pix_s1;
        end
    end

    assign xclk        = r_xclk;
    assign w_pclk_rise = r_pclk_sh[1] & ~r_pclk_sh[2];
    assign w_vs_fall   = ~r_vs_sh[1] & r_vs_sh[2];
    assign w_vs_rise   = r_vs_sh[1] & ~r_vs_sh[2];
    assign w_href_fall = ~r_href_sh[1] & r_href_sh[2];

    // Bus decode; register writes take effect on the request edge.
    assign w_addr    = wb_adr_i[4:2];
    assign w_req     = wb_stb_i & wb_cyc_i & ~r_ack;
    assign w_wr      = w_req & wb_we_i;
    assign w_ctrl_wr = w_wr & (w_addr == REG_CTRL);
    assign w_stat_wr = w_wr & (w_addr == REG_STATUS);
    assign w_abort   = w_ctrl_wr & ~wb_dat_i[CTRL_EN];
    assign w_flush   = w_ctrl_wr & wb_dat_i[CTRL_FLUSH];

    assign w_start     = (r_state == S_WAIT_VS) & w_vs_fall;
    assign w_frame_end = (r_state == S_CAPTURE) & w_vs_rise & ~w_abort;
    assign w_pixel     = (r_state == S_CAPTURE) & w_pclk_rise & r_href_sh[1] & ~w_vs_rise;
    assign w_pack_word = r_pack_word |
                         (WB_DAT_WIDTH'(r_pix_s2) << (r_pack_cnt * PIX_WIDTH));
    assign w_pack_full = w_pixel & (r_pack_cnt == PACK_CW'(PACK - 1));
    assign w_partial   = w_frame_end & (r_pack_cnt != '0);
    assign w_push      = (w_pack_full | w_partial) & ~w_abort;
    assign w_push_data = w_pack_full ? w_pack_word : r_pack_word;
    assign w_ovf_evt   = w_push & w_full & ~r_pop_pend & ~w_flush;

    cam_sync_fifo #(.WIDTH(WB_DAT_WIDTH), .DEPTH(FIFO_DEPTH)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .i_push  (w_push),
        .i_din   (w_push_data),
        .i_pop   (r_pop_pend),
        .i_flush (w_flush),
        .o_dout  (w_dout),
        .o_level (w_level),
        .o_empty (w_empty),
        .o_full  (w_full)
    );

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE:    if (r_ctrl_en) w_state_next = S_WAIT_VS;
            S_WAIT_VS: if (w_vs_fall) w_state_next = S_CAPTURE;
            S_CAPTURE: if (w_vs_rise) w_state_next = r_ctrl_cont ? S_WAIT_VS : S_DONE;
            S_DONE:    if (r_ctrl_en) w_state_next = S_WAIT_VS;
            default:   w_state_next = S_IDLE;
        endcase
        if (w_abort) w_state_next = S_IDLE;
    end

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_state_next;
    end

    // Single-shot capture drops enable itself so DONE holds until software re-arms.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ctrl_en     <= 1'b0;
            r_ctrl_cont   <= 1'b0;
            r_ctrl_irq_en <= 1'b0;
        end else if (w_ctrl_wr) begin
            r_ctrl_en     <= wb_dat_i[CTRL_EN];
            r_ctrl_cont   <= wb_dat_i[CTRL_CONT];
            r_ctrl_irq_en <= wb_dat_i[CTRL_IRQ_EN];
        end else if (w_frame_end && !r_ctrl_cont) begin
            r_ctrl_en <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst || w_flush || w_abort || w_start || w_frame_end) begin
            r_pack_cnt  <= '0;
            r_pack_word <= '0;
        end else if (w_pixel) begin
            if (w_pack_full) begin
                r_pack_cnt  <= '0;
                r_pack_word <= '0;
            end else begin
                r_pack_cnt  <= r_pack_cnt + 1'b1;
                r_pack_word <= w_pack_word;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_line_pix   <= '0;
            r_last_line  <= '0;
            r_line_cnt   <= '0;
            r_geom_pix   <= '0;
            r_geom_lines <= '0;
            r_frame_cnt  <= '0;
        end else if (w_start) begin
            r_line_pix  <= '0;
            r_last_line <= '0;
            r_line_cnt  <= '0;
        end else if (r_state == S_CAPTURE) begin
            if (w_pixel) r_line_pix <= r_line_pix + 16'd1;
            if (w_href_fall) begin
                r_last_line <= r_line_pix;
                r_line_pix  <= '0;
                r_line_cnt  <= r_line_cnt + 16'd1;
            end
            if (w_frame_end) begin
                r_geom_pix   <= r_last_line;
                r_geom_lines <= r_line_cnt;
                r_frame_cnt  <= r_frame_cnt + 16'd1;
            end
        end
    end

    // Sticky flags: a new event in the same cycle as a clear keeps the flag set.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ovf        <= 1'b0;
            r_frame_done <= 1'b0;
            r_irq        <= 1'b0;
        end else begin
            if (w_ovf_evt)                         r_ovf <= 1'b1;
            else if (w_stat_wr && wb_dat_i[ST_OVF]) r_ovf <= 1'b0;
            if (w_frame_end)                        r_frame_done <= 1'b1;
            else if (w_stat_wr && wb_dat_i[ST_DONE]) r_frame_done <= 1'b0;
            r_irq <= r_ctrl_irq_en & (r_ovf | r_frame_done);
        end
    end

    always_comb begin
        w_rd_data = '0;
        case (w_addr)
            REG_CTRL:      w_rd_data[3:0]   = {r_ctrl_irq_en, 1'b0, r_ctrl_cont, r_ctrl_en};
            REG_STATUS:    w_rd_data[15:0]  = {8'(w_level), 2'b00, r_state, r_frame_done,
                                               r_ovf, w_full, w_empty};
            REG_DATA:      if (!w_empty) w_rd_data = w_dout;
            REG_FRAME_CNT: w_rd_data[15:0]  = r_frame_cnt;
            REG_GEOM:      w_rd_data[31:0]  = {r_geom_lines, r_geom_pix};
            default:       w_rd_data = '0;
        endcase
    end

    // The DATA pop is deferred to the ack cycle and only when a word was returned.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ack      <= 1'b0;
            r_dat_o    <= '0;
            r_pop_pend <= 1'b0;
        end else begin
            r_ack      <= w_req;
            r_dat_o    <= (w_req && !wb_we_i) ? w_rd_data : '0;
            r_pop_pend <= w_req & ~wb_we_i & (w_addr == REG_DATA) & ~w_empty;
        end
    end

    assign wb_ack_o = r_ack;
    assign wb_dat_o = r_dat_o;
    assign irq      = r_irq;

endmodule

// File: doc/wb_cam_capture.md
Name: wb_cam_capture

Overview:
- Wishbone-slave camera capture block for an OV-style parallel sensor (xclk out; pclk/href/vsync/data in).
- Oversamples sensor signals in the clk domain and packs pixels into WB_DAT_WIDTH words.
- Buffers the words in a FIFO that the CPU drains over Wishbone.
- Adds single-shot/continuous frame modes, frame/line statistics, overflow detection and an interrupt.

Parameters:
- WB_DAT_WIDTH, 32, Wishbone data width; multiple of PIX_WIDTH.
- WB_ADR_WIDTH, 32, Wishbone byte-address width.
- PIX_WIDTH, 8, sensor data bus width; PACK = WB_DAT_WIDTH/PIX_WIDTH pixels per word.
- FIFO_DEPTH, 16, words; power of 2, at least 4.
- XCLK_DIV, 2, xclk toggles every XCLK_DIV clk cycles; at least 1.

Ports:
- clk  in  1  system clock; must be at least 4x pclk.
- rst  in  1  synchronous active-high reset.
- xclk  out  1  sensor master clock.
- pclk  in  1  sensor pixel clock (asynchronous).
- href  in  1  line valid.
- vsync  in  1  frame sync; high = vertical blank.
- pix_d  in  PIX_WIDTH  sensor pixel data.
- wb_adr_i  in  WB_ADR_WIDTH  byte address; bits [4:2] decode the register.
- wb_dat_i  in  WB_DAT_WIDTH  write data.
- wb_we_i  in  1  write enable.
- wb_cyc_i  in  1  bus cycle.
- wb_stb_i  in  1  strobe.
- wb_sel_i  in  WB_DAT_WIDTH/8  byte selects; ignored, all accesses are full-word.
- wb_dat_o  out  WB_DAT_WIDTH  read data, registered.
- wb_ack_o  out  1  acknowledge.
- irq  out  1  level interrupt.

Behaviour:
- Reset state: rst is synchronous and active-high on clk.
  - While rst is high: all outputs 0; FIFO empty; counters 0; CTRL 0; state IDLE; xclk low.
- xclk: free-running divider, toggles every XCLK_DIV clk cycles; runs in every state.
- Input sync:
  - pclk, href, vsync and pix_d pass through a 2-FF synchronizer plus one history stage.
  - pclk_rise = s2 & ~s3; vs_fall / vs_rise are detected the same way.
  - Pixel value and href are taken from stage s2 in the cycle pclk_rise is seen.
- Registers, selected by wb_adr_i[4:2]:
  - 0 CTRL (RW):
    - bit0 enable.
    - bit1 continuous.
    - bit2 flush: self-clearing, empties FIFO, discards partial word.
    - bit3 irq_en.
  - 1 STATUS (R; bits 2 and 3 write-1-to-clear):
    - bit0 empty; bit1 full; bit2 overflow (sticky); bit3 frame_done (sticky).
    - [5:4] state; [15:8] FIFO level.
  - 2 DATA (R): pops one FIFO word. If empty, returns 0, no pop, no side effect.
  - 3 FRAME_CNT (R): [15:0] completed frames; wraps 0xFFFF to 0.
  - 4 GEOM (R): [15:0] pixels in last completed line; [31:16] lines in last completed frame.
  - Other addresses: reads return 0; writes are ignored.
- Wishbone:
  - Request = stb & cyc & ~ack.
  - ack asserts the cycle after the request for exactly one cycle; throughput is one access per 2 cycles.
  - wb_dat_o is valid with ack. The DATA pop happens in the ack cycle.
- FSM (IDLE=0, WAIT_VS=1, CAPTURE=2, DONE=3):
  - IDLE: enable=1 -> WAIT_VS.
  - WAIT_VS: vs_fall -> CAPTURE; clear pixel, line and pack counters.
  - CAPTURE:
    - Each pclk_rise with href=1 shifts the pixel into the pack register, first pixel at bits [PIX_WIDTH-1:0].
    - When PACK pixels are collected, push the word.
    - href falling edge: latch the line pixel count, increment the line count.
    - vs_rise = end of frame:
      - Push the partial word, zero-padded in the upper bits, if nonempty.
      - Latch GEOM, increment FRAME_CNT, set frame_done.
      - continuous=1 -> WAIT_VS; else -> DONE and clear enable.
  - DONE: enable=1 -> WAIT_VS.
  - Writing enable=0 -> IDLE from any state next cycle; the partial word is discarded and the FIFO is kept.
- FIFO:
  - A push while full drops the word and sets overflow; stored contents are unchanged.
  - Push and pop in the same cycle: level unchanged; data order preserved.
  - A pop of an empty FIFO coinciding with a push returns 0; the pushed word remains.
  - Flush and push in the same cycle: flush wins.
- irq = irq_en & (overflow | frame_done), registered, 1-cycle latency.

Decomposition:
- Package wb_cam_pkg:
  - Register offsets.
  - CTRL and STATUS bit indices.
  - FSM state encoding (2-bit).
  - Helper function for PACK and the log2 of FIFO_DEPTH.
- Sub-module cam_sync_fifo:
  - Parameters: width, depth.
  - Signals: push, pop, flush, dout, level, empty, full.
  - Single clock, first-word-fall-through.

Test Plan:
- Reset and xclk:
  - Stimulus: assert rst for 3 cycles with XCLK_DIV=2.
  - Required: all registers read 0, STATUS=0x0001, xclk period = 4 clk cycles.
- Single-shot frame:
  - Stimulus: CTRL=0x1; frame of 2 lines x 4 pixels, data 0x11..0x18.
  - Required:
    - DATA reads 0x14131211, 0x18171615, then 0.
    - GEOM=0x00020004, FRAME_CNT=1, state=DONE, CTRL bit0=0.
- Partial word:
  - Stimulus: 1 line x 6 pixels 0xA1..0xA6.
  - Required: words 0xA4A3A2A1 and 0x0000A6A5.
- Overflow:
  - Stimulus: FIFO_DEPTH=4, frame of 24 pixels, no reads.
  - Required:
    - full=1, overflow=1, level=4.
    - First 4 words intact.
    - irq=1 when irq_en=1.
    - Writing STATUS=0x4 clears overflow.
- Continuous mode:
  - Stimulus: CTRL=0x3; 3 frames.
  - Required: FRAME_CNT=3, state back to WAIT_VS after each vs_rise.
- Abort mid-line:
  - Stimulus: write CTRL=0 after 2 pixels.
  - Required: state=IDLE next cycle, no partial word pushed, FIFO level unchanged.
